// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered UART transmitter with runtime baud, parity and stop-bit selection
module uart_tx_fifo #(
    parameter int CLK_HZ     = 50000000,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk_50mhz,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic [2:0]                  baud,
    input  logic [1:0]                  parity,
    input  logic                        stop2,
    output logic                        full,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt,
    output logic                        overflow,
    output logic                        tx_busy,
    output logic                        tx_data,
    output logic                        tx_done
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int DIV_W = $clog2(CLK_HZ / 9600) + 1;

    localparam logic [DIV_W-1:0] DIV_9600   = DIV_W'(CLK_HZ / 9600 - 1);
    localparam logic [DIV_W-1:0] DIV_19200  = DIV_W'(CLK_HZ / 19200 - 1);
    localparam logic [DIV_W-1:0] DIV_38400  = DIV_W'(CLK_HZ / 38400 - 1);
    localparam logic [DIV_W-1:0] DIV_57600  = DIV_W'(CLK_HZ / 57600 - 1);
    localparam logic [DIV_W-1:0] DIV_115200 = DIV_W'(CLK_HZ / 115200 - 1);
    localparam logic [AW:0]      DEPTH      = (AW + 1)'(FIFO_DEPTH);
    localparam logic [2:0]       LAST_BIT   = 3'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              ready_q;
    logic              push;
    logic              pop;

    state_t            state;
    logic [DIV_W-1:0]  bit_cnt;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_sel;
    logic [2:0]        bit_idx;
    logic              stop_idx;
    logic [DATA_W-1:0] shift_q;
    logic              par_bit_q;
    logic              par_en_q;
    logic              stop2_q;
    logic              tick;
    logic              frame_end;

    always_comb begin
        div_sel = DIV_9600;
        case (baud)
            3'd1:    div_sel = DIV_19200;
            3'd2:    div_sel = DIV_38400;
            3'd3:    div_sel = DIV_57600;
            3'd4:    div_sel = DIV_115200;
            default: div_sel = DIV_9600;
        endcase
    end

    assign full      = (fifo_cnt == DEPTH);
    assign push      = wr_en && !full;
    assign tick      = (bit_cnt == div_q);
    assign frame_end = (state == STOP) && tick && (stop_idx || !stop2_q);
    // Idle start waits on the registered non-empty flag so a fresh write reaches the line two edges later.
    assign pop       = (fifo_cnt != '0) && (((state == IDLE) && ready_q) || frame_end);

    always_ff @(posedge clk_50mhz) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            overflow <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            overflow <= wr_en && full;
            ready_q  <= (fifo_cnt != '0);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (AW + 1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (AW + 1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            div_q     <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            shift_q   <= '0;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
            stop2_q   <= 1'b0;
            tx_data   <= 1'b1;
            tx_done   <= 1'b0;
            tx_busy   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            bit_cnt <= tick ? '0 : bit_cnt + DIV_W'(1);
            case (state)
                IDLE: bit_cnt <= '0;
                START: begin
                    if (tick) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        tx_data <= shift_q[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == LAST_BIT) begin
                            if (par_en_q) begin
                                state   <= PARITY;
                                tx_data <= par_bit_q;
                            end else begin
                                state    <= STOP;
                                stop_idx <= 1'b0;
                                tx_data  <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_data <= shift_q[1];
                            shift_q <= shift_q >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        state    <= STOP;
                        stop_idx <= 1'b0;
                        tx_data  <= 1'b1;
                    end
                end
                STOP: begin
                    if (frame_end) begin
                        tx_done <= 1'b1;
                        state   <= IDLE;
                        tx_busy <= 1'b0;
                    end else if (tick) begin
                        stop_idx <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // Frame setup is latched here so mid-frame input changes only affect the next frame.
            if (pop) begin
                state     <= START;
                bit_cnt   <= '0;
                tx_data   <= 1'b0;
                tx_busy   <= 1'b1;
                shift_q   <= mem[rd_ptr];
                par_bit_q <= (^mem[rd_ptr]) ^ parity[1];
                par_en_q  <= parity[0] ^ parity[1];
                div_q     <= div_sel;
                stop2_q   <= stop2;
            end
        end
    end
endmodule
